// File: rtl/ifetch_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_bridge_pkg
//  Description : Shared bus widths, zero word, fetch-bridge FSM state
//                encodings and the NOP instruction used on failed fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
package ifetch_bridge_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0] ZeroWord = '0;

    // Fetch bridge FSM encodings
    localparam logic [0:0] IFB_IDLE = 1'b0;
    localparam logic [0:0] IFB_REQ  = 1'b1;

    // Instruction delivered when the memory errors or times out
    localparam logic [InstBus-1:0] IFB_NOP = ZeroWord;

endpackage
`default_nettype wire

// File: rtl/ifetch_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_bridge
//  Description : Instruction-fetch bridge between the core fetch port and a
//                multi-cycle req/ack instruction memory. A one-entry fetch
//                buffer serves hits combinationally; misses stall the core
//                while the memory is asked for the word. Bus errors and
//                timeouts fill the buffer with a NOP and pulse err_o.
//  Ports       : clk, rst (sync, active-low)
//                rom_ce_i / rom_addr_i / rom_data_o / stallreq_o : core side
//                flush_i    : invalidate buffer, discard in-flight fill
//                mem_req_o / mem_addr_o / mem_ack_i / mem_rdata_i /
//                mem_err_i  : memory handshake
//                err_o      : one-cycle pulse on bus error or timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_bridge
    import ifetch_bridge_pkg::*;
#(
    parameter int ADDR_W  = InstAddrBus,
    parameter int DATA_W  = InstBus,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [ADDR_W-1:0] rom_addr_i,
    output logic [DATA_W-1:0] rom_data_o,
    output logic              stallreq_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_err_i,
    output logic              err_o
);

    // Counter only has to reach TIMEOUT-1
    localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic               r_buf_valid;
    logic [ADDR_W-1:0]  r_buf_addr;
    logic [DATA_W-1:0]  r_buf_data;
    logic               r_drop;
    logic [c_cnt_w-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_err;

    logic w_hit;
    logic w_miss;
    logic w_in_req;
    logic w_start;
    logic w_timeout;
    logic w_done;
    logic w_fail;

    // Byte-offset bits take no part in the tag compare
    logic w_unused;
    assign w_unused = ^{rom_addr_i[1:0], r_buf_addr[1:0]};

    assign w_hit     = rom_ce_i && r_buf_valid &&
                       (r_buf_addr[ADDR_W-1:2] == rom_addr_i[ADDR_W-1:2]);
    assign w_miss    = rom_ce_i && !w_hit;
    assign w_in_req  = (r_state == IFB_REQ);
    assign w_start   = (r_state == IFB_IDLE) && w_miss && !flush_i;
    // An ack in the final allowed cycle wins over the timeout
    assign w_timeout = w_in_req && !mem_ack_i && (r_cnt == c_cnt_last);
    assign w_done    = (w_in_req && mem_ack_i) || w_timeout;
    assign w_fail    = (w_in_req && mem_ack_i && mem_err_i) || w_timeout;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IFB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IFB_IDLE: if (w_start) w_next_state = IFB_REQ;
            IFB_REQ:  if (w_done)  w_next_state = IFB_IDLE;
            default:  w_next_state = IFB_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_o  = w_in_req;
        mem_addr_o = r_mem_addr;
        stallreq_o = w_miss;
        rom_data_o = w_hit ? r_buf_data : '0;
        err_o      = r_err;
    end

    // ------------------------------------------------------------------
    // Fetch buffer, request address, timeout counter, drop flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
            r_drop      <= 1'b0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_fail;

            if (w_start) begin
                r_mem_addr <= {rom_addr_i[ADDR_W-1:2], 2'b00};
                r_cnt      <= '0;
            end else if (w_in_req && !w_done) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end

            // A flush while waiting lets the handshake finish but
            // throws away whatever it returns
            if (w_done) begin
                r_drop <= 1'b0;
            end else if (w_in_req && flush_i) begin
                r_drop <= 1'b1;
            end

            if (flush_i) begin
                r_buf_valid <= 1'b0;
            end else if (w_done && !r_drop) begin
                r_buf_valid <= 1'b1;
                r_buf_addr  <= r_mem_addr;
                r_buf_data  <= w_fail ? DATA_W'(IFB_NOP) : mem_rdata_i;
            end
        end
    end

endmodule
`default_nettype wire
